// File: rtl/phase_freq_detector_if.sv
// Signal bundle between the phase/frequency detector and its driver/consumer.
`timescale 1ns/1ps
interface phase_freq_detector_if #(
  parameter int unsigned WIDTH = 8
);
  logic             reference_i;
  logic             generated_i;
  logic             both_edges_i;
  logic [WIDTH-1:0] pd_clock_cycles_o;
  logic             pd_valid_o;
  logic             saturated_o;
  logic             slip_o;
  logic             locked_o;

  modport master (
    output reference_i, generated_i, both_edges_i,
    input  pd_clock_cycles_o, pd_valid_o, saturated_o, slip_o, locked_o
  );

  modport slave (
    input  reference_i, generated_i, both_edges_i,
    output pd_clock_cycles_o, pd_valid_o, saturated_o, slip_o, locked_o
  );
endinterface

// File: rtl/phase_freq_detector.sv
// Signed reference/generated edge offset measurement with saturation,
// cycle-slip detection, a result strobe and a lock indicator.
`timescale 1ns/1ps
module phase_freq_detector #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_TOL    = 4,
  parameter int unsigned LOCK_COUNT  = 8
) (
  input  logic                 fpga_clk_i,
  input  logic                 reset_i,
  phase_freq_detector_if.slave pfd
);

  localparam int unsigned CW = WIDTH - 1;
  localparam int unsigned LW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [LW-1:0] LOCK_FULL = LW'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, GEN_LEAD, REF_LEAD} state_e;

  logic [SYNC_STAGES-1:0] ref_sync_q, ref_sync_d, gen_sync_q, gen_sync_d;
  logic                   ref_hist_q, ref_hist_d, gen_hist_q, gen_hist_d;
  logic                   mode_q, mode_d;
  logic                   ref_edge, gen_edge;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic                   sat_q, sat_d, sat_inc;
  logic [WIDTH-1:0]       res_mag;

  logic [WIDTH-1:0]       pd_q, pd_d;
  logic                   valid_q, valid_d;
  logic                   sat_out_q, sat_out_d;
  logic                   slip_q, slip_d;
  logic [LW-1:0]          lock_cnt_q, lock_cnt_d;
  logic                   locked_q, locked_d;
  logic [WIDTH-1:0]       err_mag;

  // Synchroniser shift, edge history and registered edge-mode select
  always_comb begin
    ref_sync_d = {ref_sync_q[SYNC_STAGES-2:0], pfd.reference_i};
    gen_sync_d = {gen_sync_q[SYNC_STAGES-2:0], pfd.generated_i};
    ref_hist_d = ref_sync_q[SYNC_STAGES-1];
    gen_hist_d = gen_sync_q[SYNC_STAGES-1];
    mode_d     = pfd.both_edges_i;
    ref_edge   = mode_q ? (ref_hist_d ^ ref_hist_q) : (ref_hist_d & ~ref_hist_q);
    gen_edge   = mode_q ? (gen_hist_d ^ gen_hist_q) : (gen_hist_d & ~gen_hist_q);
  end

  // Measurement FSM: next state, lead counter, result and slip strobe
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    pd_d      = pd_q;
    valid_d   = 1'b0;
    sat_out_d = sat_out_q;
    slip_d    = 1'b0;
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    sat_inc   = sat_q | (cnt_q == CNT_MAX);
    res_mag   = {1'b0, (sat_q ? CNT_MAX : cnt_q)};
    unique case (state_q)
      IDLE: begin
        if (gen_edge && ref_edge) begin
          pd_d      = '0;
          valid_d   = 1'b1;
          sat_out_d = 1'b0;
        end else if (gen_edge) begin
          state_d = GEN_LEAD;
          cnt_d   = CW'(1);
          sat_d   = 1'b0;
        end else if (ref_edge) begin
          state_d = REF_LEAD;
          cnt_d   = CW'(1);
          sat_d   = 1'b0;
        end
      end
      GEN_LEAD: begin
        if (ref_edge) begin
          pd_d      = res_mag;
          valid_d   = 1'b1;
          sat_out_d = sat_q;
          state_d   = IDLE;
          cnt_d     = '0;
          sat_d     = 1'b0;
        end else if (gen_edge) begin
          slip_d = 1'b1;
          cnt_d  = CW'(1);
          sat_d  = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          sat_d = sat_inc;
        end
      end
      REF_LEAD: begin
        if (gen_edge) begin
          pd_d      = WIDTH'(0) - res_mag;
          valid_d   = 1'b1;
          sat_out_d = sat_q;
          state_d   = IDLE;
          cnt_d     = '0;
          sat_d     = 1'b0;
        end else if (ref_edge) begin
          slip_d = 1'b1;
          cnt_d  = CW'(1);
          sat_d  = 1'b0;
        end else begin
          cnt_d = cnt_inc;
          sat_d = sat_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lock tracking driven by the registered result and slip strobes
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    err_mag    = pd_q[WIDTH-1] ? (~pd_q + WIDTH'(1)) : pd_q;
    if (slip_q) begin
      lock_cnt_d = '0;
    end else if (valid_q) begin
      if (!sat_out_q && (err_mag <= WIDTH'(LOCK_TOL))) begin
        lock_cnt_d = (lock_cnt_q == LOCK_FULL) ? lock_cnt_q : lock_cnt_q + LW'(1);
      end else begin
        lock_cnt_d = '0;
      end
    end
    locked_d = (lock_cnt_d == LOCK_FULL);
  end

  // All state, with reset dominant over every other event
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      ref_sync_q <= '0;
      gen_sync_q <= '0;
      ref_hist_q <= 1'b0;
      gen_hist_q <= 1'b0;
      mode_q     <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      pd_q       <= '0;
      valid_q    <= 1'b0;
      sat_out_q  <= 1'b0;
      slip_q     <= 1'b0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      ref_sync_q <= ref_sync_d;
      gen_sync_q <= gen_sync_d;
      ref_hist_q <= ref_hist_d;
      gen_hist_q <= gen_hist_d;
      mode_q     <= mode_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      pd_q       <= pd_d;
      valid_q    <= valid_d;
      sat_out_q  <= sat_out_d;
      slip_q     <= slip_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign pfd.pd_clock_cycles_o = pd_q;
  assign pfd.pd_valid_o        = valid_q;
  assign pfd.saturated_o       = sat_out_q;
  assign pfd.slip_o            = slip_q;
  assign pfd.locked_o          = locked_q;

endmodule

// File: tb/tb_phase_freq_detector.sv
// Testbench for phase_freq_detector: vector table plus corner-case sequences,
// results checked through an expected-result queue.
`timescale 1ns/1ps
module tb_phase_freq_detector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #1.25 clk = ~clk;

  phase_freq_detector_if #(.WIDTH(8)) pfd();

  phase_freq_detector #(
    .WIDTH(8), .SYNC_STAGES(2), .LOCK_TOL(4), .LOCK_COUNT(8)
  ) dut (
    .fpga_clk_i (clk),
    .reset_i    (rst),
    .pfd        (pfd.slave)
  );

  typedef struct packed {
    logic [7:0] val;
    logic       sat;
  } exp_t;

  typedef struct {
    bit         gen_first;
    int         lead;
    logic [7:0] val;
    logic       sat;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vcnt   = 0;
  int   scnt   = 0;

  // Scoreboard: every valid result is matched against the oldest expectation
  always @(negedge clk) begin
    if (pfd.slip_o) scnt++;
    if (pfd.pd_valid_o) begin
      exp_t e;
      vcnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid got %h sat %b required no result",
                 pfd.pd_clock_cycles_o, pfd.saturated_o);
      end else begin
        e = exp_q.pop_front();
        if (pfd.pd_clock_cycles_o !== e.val || pfd.saturated_o !== e.sat) begin
          errors++;
          $display("FAIL result got %h sat %b required %h sat %b",
                   pfd.pd_clock_cycles_o, pfd.saturated_o, e.val, e.sat);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #0.5;
  endtask

  task automatic push(input logic [7:0] v, input logic s);
    exp_t e;
    e.val = v;
    e.sat = s;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    check(name, int'({pfd.pd_clock_cycles_o, pfd.pd_valid_o, pfd.saturated_o,
                      pfd.slip_o, pfd.locked_o}), 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #0.5;
    check("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_valid();
    bit got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #0.5;
      if (pfd.pd_valid_o) begin
        got = 1'b1;
        break;
      end
    end
    check("valid_timeout", int'(got), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2);
  endtask

  // One leading edge, the lagging edge 'lead' cycles later, then release
  task automatic measure(input bit gen_first, input int lead,
                         input logic [7:0] v, input logic s);
    push(v, s);
    if (lead == 0) begin
      pfd.generated_i = 1'b1;
      pfd.reference_i = 1'b1;
    end else begin
      if (gen_first) pfd.generated_i = 1'b1;
      else           pfd.reference_i = 1'b1;
      cyc(lead);
      pfd.generated_i = 1'b1;
      pfd.reference_i = 1'b1;
    end
    cyc(4);
    pfd.generated_i = 1'b0;
    pfd.reference_i = 1'b0;
    cyc(10);
    drain();
  endtask

  // Gen-leads measurement that also checks locked_o one cycle after the valid
  task automatic lock_meas(input int lead, input int exp_locked);
    push(8'(lead), 1'b0);
    pfd.generated_i = 1'b1;
    cyc(lead);
    pfd.reference_i = 1'b1;
    wait_valid();
    cyc(1);
    check("locked_after_valid", int'(pfd.locked_o), exp_locked);
    pfd.generated_i = 1'b0;
    pfd.reference_i = 1'b0;
    cyc(8);
    drain();
  endtask

  // One input period, gen leading ref by 10 cycles on both edges
  task automatic both_period(input bit both_mode);
    pfd.generated_i = 1'b1;
    push(8'h0A, 1'b0);
    cyc(10);
    pfd.reference_i = 1'b1;
    cyc(10);
    pfd.generated_i = 1'b0;
    if (both_mode) push(8'h0A, 1'b0);
    cyc(10);
    pfd.reference_i = 1'b0;
    cyc(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int   v0;
    vecs[0] = '{gen_first: 1'b1, lead: 10,  val: 8'h0A, sat: 1'b0};
    vecs[1] = '{gen_first: 1'b0, lead: 10,  val: 8'hF6, sat: 1'b0};
    vecs[2] = '{gen_first: 1'b1, lead: 0,   val: 8'h00, sat: 1'b0};
    vecs[3] = '{gen_first: 1'b1, lead: 200, val: 8'h7F, sat: 1'b1};
    vecs[4] = '{gen_first: 1'b0, lead: 200, val: 8'h81, sat: 1'b1};
    vecs[5] = '{gen_first: 1'b1, lead: 127, val: 8'h7F, sat: 1'b0};
    vecs[6] = '{gen_first: 1'b1, lead: 128, val: 8'h7F, sat: 1'b1};
    vecs[7] = '{gen_first: 1'b0, lead: 3,   val: 8'hFD, sat: 1'b0};

    pfd.generated_i  = 1'b0;
    pfd.reference_i  = 1'b0;
    pfd.both_edges_i = 1'b0;
    cyc(3);
    check_zero_outputs("reset_outputs");
    rst = 1'b0;
    cyc(3);

    for (int i = 0; i < 8; i++) begin
      measure(vecs[i].gen_first, vecs[i].lead, vecs[i].val, vecs[i].sat);
    end
    check("no_slip_in_table", scnt, 0);

    // Slip: two gen edges 100 cycles apart, ref 6 cycles after the second
    do_reset();
    scnt = 0;
    pfd.generated_i = 1'b1;
    cyc(4);
    pfd.generated_i = 1'b0;
    cyc(96);
    pfd.generated_i = 1'b1;
    push(8'h06, 1'b0);
    cyc(6);
    pfd.reference_i = 1'b1;
    cyc(4);
    pfd.generated_i = 1'b0;
    pfd.reference_i = 1'b0;
    cyc(10);
    drain();
    check("slip_pulses", scnt, 1);

    // Lock after eight +3 results
    do_reset();
    for (int k = 0; k < 8; k++) lock_meas(3, (k == 7) ? 1 : 0);
    lock_meas(3, 1);

    // Reset mid-measurement clears outputs and the half-done measurement
    pfd.generated_i = 1'b1;
    cyc(5);
    rst = 1'b1;
    pfd.generated_i = 1'b0;
    cyc(1);
    check_zero_outputs("reset_mid_outputs");
    cyc(2);
    rst = 1'b0;
    v0 = vcnt;
    cyc(3);
    pfd.reference_i = 1'b1;
    cyc(30);
    check("no_stray_valid", vcnt - v0, 0);
    pfd.reference_i = 1'b0;
    do_reset();

    // Relock, then an out-of-tolerance result drops lock
    for (int k = 0; k < 8; k++) lock_meas(3, (k == 7) ? 1 : 0);
    lock_meas(20, 0);

    // Both-edges mode gives two results per period, rising-only gives one
    do_reset();
    pfd.both_edges_i = 1'b1;
    cyc(3);
    v0 = vcnt;
    both_period(1'b1);
    both_period(1'b1);
    drain();
    check("both_edges_valids", vcnt - v0, 4);
    pfd.both_edges_i = 1'b0;
    cyc(3);
    v0 = vcnt;
    both_period(1'b0);
    both_period(1'b0);
    drain();
    check("rising_only_valids", vcnt - v0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
